// File: rtl/rsa_control.sv
// rtl/rsa_control.sv - RSA key setup (n, phi, d = E^-1 mod phi) and square-and-multiply modular exponentiation.
// Optional build macro MODEXP_EARLY_EXIT_EN: skip leading zero exponent bits and stop once the remaining bits are zero.
module rsa_control #(
  parameter int WIDTH = 128,
  parameter int E     = 65537
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   q,
  input  logic               reset_inverter,
  input  logic               reset_mod_exp,
  input  logic               encrypt_decrypt,
  input  logic [2*WIDTH-1:0] msg_in,
  output logic               inverter_finish,
  output logic [2*WIDTH-1:0] msg_out,
  output logic               mod_exp_finish
);
  localparam int NW = 2 * WIDTH;
  localparam int CW = $clog2(NW + 1);
  localparam logic [NW-1:0] E_VAL = NW'(E);

  typedef enum logic [2:0] {I_IDLE, I_SETUP, I_EUCLID, I_FIX, I_DONE} inv_state_t;
  typedef enum logic [1:0] {M_IDLE, M_LOAD, M_SQMUL, M_DONE} me_state_t;

  inv_state_t inv_state;
  logic [NW-1:0] n, d, phi;
  logic [NW-1:0] mc_n, mc_phi, acc_n, acc_phi;
  logic [WIDTH-1:0] ml_n, ml_phi;
  logic [NW-1:0] r0, r1, dvd, rem;
  logic signed [NW+1:0] t0, t1, qt;
  logic div_run;
  logic [CW-1:0] icnt;

  logic [NW-1:0] acc_n_nx, acc_phi_nx;
  logic [NW:0] rem_sh;
  logic div_ge;
  logic [NW-1:0] rem_nx;
  logic signed [NW+1:0] qt_nx;
  logic [NW-1:0] d_fix;

  // qt accumulates quotient*t1 Horner-style as quotient bits appear MSB first
  always_comb begin
    acc_n_nx   = acc_n + (ml_n[0] ? mc_n : '0);
    acc_phi_nx = acc_phi + (ml_phi[0] ? mc_phi : '0);
    rem_sh     = {rem, dvd[NW-1]};
    div_ge     = rem_sh >= {1'b0, r1};
    rem_nx     = div_ge ? NW'(rem_sh - {1'b0, r1}) : rem_sh[NW-1:0];
    qt_nx      = (qt <<< 1) + (div_ge ? t1 : '0);
    d_fix      = t0[NW+1] ? NW'(t0 + $signed({2'b00, phi})) : t0[NW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_state       <= I_IDLE;
      inverter_finish <= 1'b0;
      n               <= '0;
      d               <= '0;
      phi             <= '0;
      div_run         <= 1'b0;
      icnt            <= '0;
      acc_n           <= '0;
      acc_phi         <= '0;
      mc_n            <= '0;
      mc_phi          <= '0;
      ml_n            <= '0;
      ml_phi          <= '0;
      r0              <= '0;
      r1              <= '0;
      dvd             <= '0;
      rem             <= '0;
      t0              <= '0;
      t1              <= '0;
      qt              <= '0;
    end else if (reset_inverter) begin
      inv_state       <= I_SETUP;
      inverter_finish <= 1'b0;
      mc_n            <= NW'(p);
      mc_phi          <= NW'(p - WIDTH'(1));
      ml_n            <= q;
      ml_phi          <= q - WIDTH'(1);
      acc_n           <= '0;
      acc_phi         <= '0;
      icnt            <= '0;
      div_run         <= 1'b0;
    end else begin
      case (inv_state)
        I_SETUP: begin
          acc_n   <= acc_n_nx;
          acc_phi <= acc_phi_nx;
          mc_n    <= mc_n << 1;
          mc_phi  <= mc_phi << 1;
          ml_n    <= ml_n >> 1;
          ml_phi  <= ml_phi >> 1;
          icnt    <= icnt + CW'(1);
          if (icnt == CW'(WIDTH - 1)) begin
            n         <= acc_n_nx;
            phi       <= acc_phi_nx;
            r0        <= acc_phi_nx;
            r1        <= E_VAL;
            t0        <= '0;
            t1        <= {{(NW+1){1'b0}}, 1'b1};
            inv_state <= I_EUCLID;
          end
        end
        I_EUCLID: begin
          if (!div_run) begin
            if (r1 == '0) begin
              inv_state <= I_FIX;
            end else begin
              dvd     <= r0;
              rem     <= '0;
              qt      <= '0;
              icnt    <= '0;
              div_run <= 1'b1;
            end
          end else begin
            dvd  <= dvd << 1;
            rem  <= rem_nx;
            qt   <= qt_nx;
            icnt <= icnt + CW'(1);
            if (icnt == CW'(NW - 1)) begin
              r0      <= r1;
              r1      <= rem_nx;
              t0      <= t1;
              t1      <= t0 - qt_nx;
              div_run <= 1'b0;
            end
          end
        end
        I_FIX: begin
          // r0 holds gcd(phi, E); no inverse exists unless it is 1
          d               <= (r0 == NW'(1)) ? d_fix : '0;
          inverter_finish <= 1'b1;
          inv_state       <= I_DONE;
        end
        default: ;
      endcase
    end
  end

  me_state_t me_state;
  logic [NW-1:0] result, base, k, mm_a, mb_r, mb_b;
  logic [NW+1:0] acc_r, acc_b;
  logic [CW-1:0] mcnt, bcnt;
  logic mm_run;
  logic sq_end;
  logic [NW+1:0] acc_r_nx, acc_b_nx;

  // One interleaved step: acc < m and a < m keep the sum below 3m, so two conditional subtracts suffice
  function automatic logic [NW+1:0] mm_step(input logic [NW+1:0] acc, input logic b,
                                            input logic [NW-1:0] a, input logic [NW-1:0] m);
    logic [NW+1:0] t;
    t = (acc << 1) + (b ? {2'b00, a} : '0);
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t;
  endfunction

  always_comb begin
    acc_r_nx = mm_step(acc_r, mb_r[NW-1], mm_a, n);
    acc_b_nx = mm_step(acc_b, mb_b[NW-1], mm_a, n);
  end

`ifdef MODEXP_EARLY_EXIT_EN
  logic scan;
  logic [NW-1:0] kscan;
  logic [CW-1:0] blim;
  assign sq_end = (bcnt == blim) || (k == '0);
`else
  assign sq_end = (bcnt == CW'(NW));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      me_state       <= M_IDLE;
      mod_exp_finish <= 1'b0;
      msg_out        <= '0;
      mm_run         <= 1'b0;
      result         <= '0;
      base           <= '0;
      k              <= '0;
      mm_a           <= '0;
      mb_r           <= '0;
      mb_b           <= '0;
      acc_r          <= '0;
      acc_b          <= '0;
      mcnt           <= '0;
      bcnt           <= '0;
`ifdef MODEXP_EARLY_EXIT_EN
      scan           <= 1'b0;
      kscan          <= '0;
      blim           <= '0;
`endif
    end else if (reset_inverter) begin
      me_state       <= M_IDLE;
      mod_exp_finish <= 1'b0;
      mm_run         <= 1'b0;
    end else if (reset_mod_exp && inverter_finish) begin
      // base = msg_in mod n is formed as 1*msg_in through the modular multiplier
      me_state       <= M_LOAD;
      mod_exp_finish <= 1'b0;
      result         <= NW'(1);
      k              <= encrypt_decrypt ? d : E_VAL;
      mm_a           <= NW'(1);
      mb_b           <= msg_in;
      acc_b          <= '0;
      mcnt           <= '0;
      mm_run         <= 1'b0;
    end else begin
      case (me_state)
        M_LOAD: begin
          acc_b <= acc_b_nx;
          mb_b  <= mb_b << 1;
          mcnt  <= mcnt + CW'(1);
          if (mcnt == CW'(NW - 1)) begin
            base     <= acc_b_nx[NW-1:0];
            bcnt     <= '0;
            me_state <= M_SQMUL;
`ifdef MODEXP_EARLY_EXIT_EN
            scan     <= 1'b1;
            kscan    <= k;
            blim     <= CW'(NW);
`endif
          end
        end
        M_SQMUL: begin
`ifdef MODEXP_EARLY_EXIT_EN
          if (scan) begin
            if (blim != '0 && !kscan[NW-1]) begin
              kscan <= kscan << 1;
              blim  <= blim - CW'(1);
            end else begin
              scan <= 1'b0;
            end
          end else
`endif
          if (!mm_run) begin
            if (sq_end) begin
              msg_out        <= result;
              mod_exp_finish <= 1'b1;
              me_state       <= M_DONE;
            end else begin
              acc_r  <= '0;
              acc_b  <= '0;
              mb_r   <= result;
              mb_b   <= base;
              mm_a   <= base;
              mcnt   <= '0;
              mm_run <= 1'b1;
            end
          end else begin
            acc_r <= acc_r_nx;
            acc_b <= acc_b_nx;
            mb_r  <= mb_r << 1;
            mb_b  <= mb_b << 1;
            mcnt  <= mcnt + CW'(1);
            if (mcnt == CW'(NW - 1)) begin
              if (k[0]) result <= acc_r_nx[NW-1:0];
              base   <= acc_b_nx[NW-1:0];
              k      <= k >> 1;
              bcnt   <= bcnt + CW'(1);
              mm_run <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_control.sv
// tb/tb_rsa_control.sv - randomized self-checking bench for rsa_control against an arithmetic RSA model.
module tb_rsa_control;
  localparam int E8  = 17;
  localparam int E16 = 65537;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  p8, q8;
  logic        ri8, rm8, ed8;
  logic [15:0] msg8, mo8;
  logic        if8, mf8;

  logic [15:0] p16, q16;
  logic        ri16, rm_e, rm_d;
  logic [31:0] msg16, mo_e, mo_d;
  logic        if_e, mf_e, if_d, mf_d;

  rsa_control #(.WIDTH(8), .E(E8)) dut (
    .clk(clk), .rst_n(rst_n), .p(p8), .q(q8), .reset_inverter(ri8), .reset_mod_exp(rm8),
    .encrypt_decrypt(ed8), .msg_in(msg8), .inverter_finish(if8), .msg_out(mo8), .mod_exp_finish(mf8));

  rsa_control #(.WIDTH(16), .E(E16)) enc (
    .clk(clk), .rst_n(rst_n), .p(p16), .q(q16), .reset_inverter(ri16), .reset_mod_exp(rm_e),
    .encrypt_decrypt(1'b0), .msg_in(msg16), .inverter_finish(if_e), .msg_out(mo_e), .mod_exp_finish(mf_e));

  rsa_control #(.WIDTH(16), .E(E16)) dec (
    .clk(clk), .rst_n(rst_n), .p(p16), .q(q16), .reset_inverter(ri16), .reset_mod_exp(rm_d),
    .encrypt_decrypt(1'b1), .msg_in(mo_e), .inverter_finish(if_d), .msg_out(mo_d), .mod_exp_finish(mf_d));

  int n_vec = 0;
  int n_err = 0;
  longint unsigned e_n, e_phi, e_d;

  int primes[50] = '{11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61, 67, 71, 73, 79, 83, 89,
                     97, 101, 103, 107, 109, 113, 127, 131, 137, 139, 149, 151, 157, 163, 167, 173,
                     179, 181, 191, 193, 197, 199, 211, 223, 227, 229, 233, 239, 241, 251};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned mpow(input longint unsigned b, input longint unsigned e,
                                           input longint unsigned m);
    longint unsigned r = 1 % m;
    b = b % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // d*e = 1 + k*phi for some k in [0, e); no such k means no inverse
  function automatic longint unsigned minv(input longint unsigned e, input longint unsigned ph);
    for (longint unsigned kk = 0; kk < e; kk++)
      if ((1 + kk * ph) % e == 0) return ((1 + kk * ph) / e) % ph;
    return 0;
  endfunction

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic flag(input int which);
    case (which)
      0: return if8;
      1: return mf8;
      2: return if_e & if_d;
      3: return mf_e;
      default: return mf_d;
    endcase
  endfunction

  task automatic wait_flag(input int which, input string tag);
    int c = 0;
    while (!flag(which) && c < 20000) begin
      tick(1);
      c++;
    end
    check(tag, 64'(flag(which)), 1);
  endtask

  task automatic key8(input int pp, input int qq);
    p8 = 8'(pp);
    q8 = 8'(qq);
    ri8 = 1'b1;
    tick(1);
    ri8 = 1'b0;
    rm8 = 1'b0;
    check("key_if_drop", 64'(if8), 0);
    check("key_mf_drop", 64'(mf8), 0);
    wait_flag(0, "inv_finish");
    e_n   = longint'(pp) * longint'(qq);
    e_phi = longint'(pp - 1) * longint'(qq - 1);
    e_d   = minv(E8, e_phi);
    check("n", 64'(dut.n), e_n);
    check("d", 64'(dut.d), e_d);
  endtask

  task automatic exp8(input int m, input bit dcr);
    msg8 = 16'(m);
    ed8 = dcr;
    rm8 = 1'b1;
    tick(1);
    rm8 = 1'b0;
    check("exp_mf_drop", 64'(mf8), 0);
    wait_flag(1, "exp_finish");
    check(dcr ? "dec_msg" : "enc_msg", 64'(mo8), mpow(longint'(m), dcr ? e_d : E8, e_n));
  endtask

  task automatic chain16(input longint unsigned pp, input longint unsigned qq);
    longint unsigned nn, dd, m;
    p16 = 16'(pp);
    q16 = 16'(qq);
    ri16 = 1'b1;
    tick(1);
    ri16 = 1'b0;
    wait_flag(2, "inv16_finish");
    nn = pp * qq;
    dd = minv(E16, (pp - 1) * (qq - 1));
    check("n16", 64'(enc.n), nn);
    check("d16", 64'(dec.d), dd);
    m = longint'($urandom_range(32'(nn - 1)));
    msg16 = 32'(m);
    rm_e = 1'b1;
    tick(1);
    rm_e = 1'b0;
    wait_flag(3, "enc16_finish");
    check("enc16", 64'(mo_e), mpow(m, E16, nn));
    rm_d = 1'b1;
    tick(1);
    rm_d = 1'b0;
    wait_flag(4, "dec16_finish");
    check("roundtrip16", 64'(mo_d), m);
  endtask

  initial begin
    rst_n = 1'b0;
    {p8, q8, ri8, rm8, ed8, msg8} = '0;
    {p16, q16, ri16, rm_e, rm_d, msg16} = '0;
    tick(2);
    check("rst_if", 64'(if8), 0);
    check("rst_mf", 64'(mf8), 0);
    check("rst_msg", 64'(mo8), 0);
    rst_n = 1'b1;
    tick(1);

    msg8 = 16'd5;
    rm8 = 1'b1;
    tick(1);
    rm8 = 1'b0;
    tick(400);
    check("start_before_key", 64'(mf8), 0);

    key8(61, 53);
    exp8(65, 1'b0);
    exp8(2790, 1'b1);
    exp8(0, 1'b0);
    exp8(1, 1'b0);
    exp8(0, 1'b1);
    exp8(1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      key8(primes[$urandom_range(49)], primes[$urandom_range(49)]);
      for (int j = 0; j < 4; j++) exp8(int'($urandom_range(32'(e_n - 1))), 1'($urandom_range(1)));
    end

    key8(103, 53);
    exp8(77, 1'b1);
    exp8(0, 1'b1);

    key8(61, 53);
    msg8 = 16'd100;
    ed8 = 1'b0;
    rm8 = 1'b1;
    tick(1);
    rm8 = 1'b0;
    tick(60);
    exp8(1234, 1'b1);

    msg8 = 16'd200;
    ed8 = 1'b1;
    rm8 = 1'b1;
    tick(1);
    rm8 = 1'b0;
    tick(50);
    key8(47, 59);
    tick(400);
    check("aborted_exp_idle", 64'(mf8), 0);
    exp8(2000, 1'b0);

    msg8 = 16'd65;
    rm8 = 1'b1;
    key8(61, 53);
    tick(400);
    check("simul_start_dropped", 64'(mf8), 0);

    msg8 = 16'd99;
    ed8 = 1'b0;
    rm8 = 1'b1;
    tick(1);
    rm8 = 1'b0;
    tick(30);
    rst_n = 1'b0;
    tick(1);
    check("midrst_if", 64'(if8), 0);
    check("midrst_mf", 64'(mf8), 0);
    check("midrst_msg", 64'(mo8), 0);
    check("midrst_n", 64'(dut.n), 0);
    check("midrst_d", 64'(dut.d), 0);
    rst_n = 1'b1;
    tick(1);

    chain16(65521, 65519);
    chain16(65519, 65521);
    chain16(251, 241);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
